// File: rtl/scratch_mem_arbiter_if.sv
// Bundle between the scratch-memory access pipe, its FSM clients, the bench test port and the memory.
// slave: the arbiter's view. master: the client/test/memory side.
interface scratch_mem_arbiter_if #(
    parameter int NUM_CH = 4,
    parameter int AW     = 12,
    parameter int DW     = 32
);
    logic                 test_mode;
    logic [AW-1:0]        test_rd_addr;
    logic [AW-1:0]        test_wr_addr;
    logic [DW-1:0]        test_wr_data;
    logic                 test_wr_en;
    logic [DW-1:0]        test_rd_data;

    logic [NUM_CH-1:0]    rd_req;
    logic [NUM_CH*AW-1:0] rd_addr;
    logic [NUM_CH-1:0]    rd_gnt;
    logic [NUM_CH-1:0]    rd_valid;
    logic [DW-1:0]        rd_data;

    logic [NUM_CH-1:0]    wr_req;
    logic [NUM_CH*AW-1:0] wr_addr;
    logic [NUM_CH*DW-1:0] wr_data;
    logic [NUM_CH-1:0]    wr_gnt;

    logic [AW-1:0]        mem_addra;
    logic [DW-1:0]        mem_dina;
    logic                 mem_wea;
    logic [AW-1:0]        mem_addrb;
    logic [DW-1:0]        mem_doutb;

    modport slave (
        input  test_mode, test_rd_addr, test_wr_addr, test_wr_data, test_wr_en,
        input  rd_req, rd_addr, wr_req, wr_addr, wr_data, mem_doutb,
        output test_rd_data, rd_gnt, rd_valid, rd_data, wr_gnt,
        output mem_addra, mem_dina, mem_wea, mem_addrb
    );

    modport master (
        output test_mode, test_rd_addr, test_wr_addr, test_wr_data, test_wr_en,
        output rd_req, rd_addr, wr_req, wr_addr, wr_data, mem_doutb,
        input  test_rd_data, rd_gnt, rd_valid, rd_data, wr_gnt,
        input  mem_addra, mem_dina, mem_wea, mem_addrb
    );
endinterface

// File: rtl/scratch_mem_arbiter.sv
// Shared scratch-memory access pipe: round-robin read/write arbitration of NUM_CH clients plus a test port.
// Define SCRATCH_ARB_FIXED_PRIO_EN to replace round-robin with fixed lowest-index-wins priority.
module scratch_mem_arbiter #(
    parameter int NUM_CH     = 4,
    parameter int AW         = 12,
    parameter int DW         = 32,
    parameter int MEM_RD_LAT = 1
) (
    input logic                  clk,
    input logic                  reset,
    scratch_mem_arbiter_if.slave bus
);
    localparam int TAG_D = 1 + MEM_RD_LAT;

    // First requester found scanning upward from start, wrapping at NUM_CH.
    function automatic logic [NUM_CH-1:0] pick(input logic [NUM_CH-1:0] req, input int start);
        logic [NUM_CH-1:0] g;
        logic [NUM_CH-1:0] r;
        int                idx;
        g = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            idx = (start + i) % NUM_CH;
            r   = req >> idx;
            if (r[0]) g = NUM_CH'(1) << idx;
        end
        return g;
    endfunction

    function automatic logic [AW-1:0] sel_addr(input logic [NUM_CH-1:0] g,
                                               input logic [NUM_CH*AW-1:0] a);
        logic [AW-1:0] s;
        s = '0;
        for (int i = 0; i < NUM_CH; i++) if (g[i]) s = a[i*AW +: AW];
        return s;
    endfunction

    function automatic logic [DW-1:0] sel_data(input logic [NUM_CH-1:0] g,
                                               input logic [NUM_CH*DW-1:0] d);
        logic [DW-1:0] s;
        s = '0;
        for (int i = 0; i < NUM_CH; i++) if (g[i]) s = d[i*DW +: DW];
        return s;
    endfunction

    logic [NUM_CH-1:0] rd_gnt_c;
    logic [NUM_CH-1:0] wr_gnt_c;

`ifdef SCRATCH_ARB_FIXED_PRIO_EN
    always_comb begin
        rd_gnt_c = '0;
        wr_gnt_c = '0;
        if (!(bus.test_mode || reset)) begin
            rd_gnt_c = pick(bus.rd_req, 0);
            wr_gnt_c = pick(bus.wr_req, 0);
        end
    end
`else
    localparam int PW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    function automatic int next_ptr(input logic [NUM_CH-1:0] g);
        int n;
        n = 0;
        for (int i = 0; i < NUM_CH; i++) if (g[i]) n = (i + 1) % NUM_CH;
        return n;
    endfunction

    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;

    always_comb begin
        rd_gnt_c = '0;
        wr_gnt_c = '0;
        if (!(bus.test_mode || reset)) begin
            rd_gnt_c = pick(bus.rd_req, int'(rd_ptr));
            wr_gnt_c = pick(bus.wr_req, int'(wr_ptr));
        end
    end

    // Grants are already zero in test mode, so the pointers hold there as well.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            if (|rd_gnt_c) rd_ptr <= PW'(next_ptr(rd_gnt_c));
            if (|wr_gnt_c) wr_ptr <= PW'(next_ptr(wr_gnt_c));
        end
    end
`endif

    // ---- stage p0: memory port registers; tag_vld_p carries the read owner alongside the memory latency
    logic [AW-1:0]     addra_p0;
    logic [DW-1:0]     dina_p0;
    logic              wea_p0;
    logic [AW-1:0]     addrb_p0;
    logic [NUM_CH-1:0] tag_vld_p [TAG_D];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addra_p0 <= '0;
            dina_p0  <= '0;
            wea_p0   <= 1'b0;
            addrb_p0 <= '0;
            for (int i = 0; i < TAG_D; i++) tag_vld_p[i] <= '0;
        end else begin
            tag_vld_p[0] <= rd_gnt_c;
            for (int i = 1; i < TAG_D; i++) tag_vld_p[i] <= tag_vld_p[i-1];
            if (bus.test_mode) begin
                addra_p0 <= bus.test_wr_addr;
                dina_p0  <= bus.test_wr_data;
                wea_p0   <= bus.test_wr_en;
                addrb_p0 <= bus.test_rd_addr;
            end else begin
                wea_p0 <= |wr_gnt_c;
                if (|wr_gnt_c) begin
                    addra_p0 <= sel_addr(wr_gnt_c, bus.wr_addr);
                    dina_p0  <= sel_data(wr_gnt_c, bus.wr_data);
                end
                if (|rd_gnt_c) addrb_p0 <= sel_addr(rd_gnt_c, bus.rd_addr);
            end
        end
    end

    // ---- stage p(MEM_RD_LAT+1): memory data returns
    assign bus.rd_gnt       = rd_gnt_c;
    assign bus.wr_gnt       = wr_gnt_c;
    assign bus.rd_valid     = tag_vld_p[TAG_D-1];
    assign bus.rd_data      = bus.mem_doutb;
    assign bus.test_rd_data = bus.mem_doutb;
    assign bus.mem_addra    = addra_p0;
    assign bus.mem_dina     = dina_p0;
    assign bus.mem_wea      = wea_p0;
    assign bus.mem_addrb    = addrb_p0;
endmodule

// File: tb/tb_scratch_mem_arbiter.sv
// Bench for scratch_mem_arbiter: directed scenarios then random client traffic against a reference model.
// Honours SCRATCH_ARB_FIXED_PRIO_EN in its reference arbitration rule.
module tb_scratch_mem_arbiter;
    localparam int N   = 4;
    localparam int AW  = 12;
    localparam int DW  = 32;
    localparam int LAT = 1;
    localparam int D   = 1 + LAT;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    scratch_mem_arbiter_if #(.NUM_CH(N), .AW(AW), .DW(DW)) bus ();

    scratch_mem_arbiter #(.NUM_CH(N), .AW(AW), .DW(DW), .MEM_RD_LAT(LAT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    function automatic logic [DW-1:0] pattern(input logic [AW-1:0] a);
        if (a == 12'h010) return 32'hDEADBEEF;
        return {20'hA5A5A, a};
    endfunction

    // Scratch memory: write port A, read-first read port B with LAT-cycle latency.
    logic [DW-1:0] mem [4096];
    bit            written [4096];
    logic [DW-1:0] dpipe [LAT];
    always @(posedge clk) begin
        if (bus.mem_wea) begin
            mem[bus.mem_addra]     <= bus.mem_dina;
            written[bus.mem_addra] <= 1'b1;
        end
        dpipe[0] <= written[bus.mem_addrb] ? mem[bus.mem_addrb] : pattern(bus.mem_addrb);
        for (int i = 1; i < LAT; i++) dpipe[i] <= dpipe[i-1];
    end
    assign bus.mem_doutb = dpipe[LAT-1];

    int            compared = 0;
    int            mismatched = 0;
    int            cyc = 0;
    int            rptr = 0;
    int            wptr = 0;
    logic [DW-1:0] ref_mem [4096];
    logic [N-1:0]  expv [int];
    logic [DW-1:0] expd [int];
    logic [DW-1:0] expt [int];
    logic [N-1:0]  last_rg = '0;
    logic [N-1:0]  last_wg = '0;
    logic [N-1:0]  rd_pend = '0;
    logic [N-1:0]  wr_pend = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Reference arbitration: first requester at or after the start index, wrapping around.
    function automatic int ref_winner(input logic [N-1:0] req, input int start);
        for (int k = 0; k < N; k++) begin
            if (req[(start + k) % N]) return (start + k) % N;
        end
        return -1;
    endfunction

    task automatic tick();
        int           rw, ww, rs, ws;
        logic [N-1:0] rg, wg, ev;
        @(negedge clk);
`ifdef SCRATCH_ARB_FIXED_PRIO_EN
        rs = 0;
        ws = 0;
`else
        rs = rptr;
        ws = wptr;
`endif
        rw = -1;
        ww = -1;
        if (!bus.test_mode) begin
            rw = ref_winner(bus.rd_req, rs);
            ww = ref_winner(bus.wr_req, ws);
        end
        rg = (rw < 0) ? '0 : (N'(1) << rw);
        wg = (ww < 0) ? '0 : (N'(1) << ww);
        chk("rd_gnt", bus.rd_gnt, rg);
        chk("wr_gnt", bus.wr_gnt, wg);
        ev = expv.exists(cyc) ? expv[cyc] : '0;
        chk("rd_valid", bus.rd_valid, ev);
        if (ev != '0) chk("rd_data", bus.rd_data, expd[cyc]);
        if (expt.exists(cyc)) chk("test_rd_data", bus.test_rd_data, expt[cyc]);
        // Reads see memory as it was before this cycle's writes land.
        if (rw >= 0) begin
            expv[cyc + D] = rg;
            expd[cyc + D] = ref_mem[bus.rd_addr[rw*AW +: AW]];
            rptr = (rw + 1) % N;
        end
        if (bus.test_mode) expt[cyc + D] = ref_mem[bus.test_rd_addr];
        if (ww >= 0) begin
            ref_mem[bus.wr_addr[ww*AW +: AW]] = bus.wr_data[ww*DW +: DW];
            wptr = (ww + 1) % N;
        end
        if (bus.test_mode && bus.test_wr_en) ref_mem[bus.test_wr_addr] = bus.test_wr_data;
        last_rg = rg;
        last_wg = wg;
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.test_mode    = 1'b0;
        bus.test_rd_addr = '0;
        bus.test_wr_addr = '0;
        bus.test_wr_data = '0;
        bus.test_wr_en   = 1'b0;
        bus.rd_req       = '0;
        bus.rd_addr      = '0;
        bus.wr_req       = '0;
        bus.wr_addr      = '0;
        bus.wr_data      = '0;
        rd_pend          = '0;
        wr_pend          = '0;
    endtask

    task automatic reset_dut();
        reset = 1'b1;
        clear_inputs();
        @(negedge clk);
        chk("rst_mem_wea", bus.mem_wea, 1'b0);
        chk("rst_mem_addra", bus.mem_addra, '0);
        chk("rst_mem_dina", bus.mem_dina, '0);
        chk("rst_mem_addrb", bus.mem_addrb, '0);
        chk("rst_rd_valid", bus.rd_valid, '0);
        chk("rst_rd_gnt", bus.rd_gnt, '0);
        chk("rst_wr_gnt", bus.wr_gnt, '0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        rptr  = 0;
        wptr  = 0;
        expv.delete();
        expd.delete();
        expt.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int a = 0; a < 4096; a++) ref_mem[a] = pattern(AW'(a));
        reset = 1'b1;
        clear_inputs();
        reset_dut();

        // Single read of a preloaded word
        bus.rd_req = 4'b0001;
        bus.rd_addr[0*AW +: AW] = 12'h010;
        tick();
        bus.rd_req = '0;
        repeat (3) tick();

        // All clients reading continuously from reset: rotation 0,1,2,3,...
        reset_dut();
        for (int i = 0; i < N; i++) bus.rd_addr[i*AW +: AW] = AW'(12'h200 + i);
        bus.rd_req = 4'b1111;
        repeat (8) tick();
        bus.rd_req = '0;
        repeat (3) tick();

        // Two writers then read back
        bus.wr_addr[1*AW +: AW] = 12'h020;
        bus.wr_data[1*DW +: DW] = 32'h11;
        bus.wr_addr[2*AW +: AW] = 12'h021;
        bus.wr_data[2*DW +: DW] = 32'h22;
        bus.wr_req = 4'b0110;
        tick();
        bus.wr_req = bus.wr_req & ~last_wg;
        tick();
        bus.wr_req = '0;
        bus.rd_addr[0*AW +: AW] = 12'h020;
        bus.rd_addr[1*AW +: AW] = 12'h021;
        bus.rd_req = 4'b0011;
        tick();
        bus.rd_req = bus.rd_req & ~last_rg;
        tick();
        bus.rd_req = '0;
        repeat (3) tick();

        // Test port owns the memory while clients request
        bus.test_mode    = 1'b1;
        bus.test_wr_en   = 1'b1;
        bus.test_wr_addr = 12'h7FF;
        bus.test_wr_data = 32'hCAFE0001;
        bus.rd_req       = 4'b1111;
        bus.wr_req       = 4'b0110;
        tick();
        bus.test_wr_en   = 1'b0;
        bus.test_rd_addr = 12'h7FF;
        repeat (3) tick();
        bus.rd_req    = '0;
        bus.wr_req    = '0;
        bus.test_mode = 1'b0;
        tick();

        // Read in flight when test mode is raised still completes
        bus.rd_addr[3*AW +: AW] = 12'h020;
        bus.rd_req = 4'b1000;
        tick();
        bus.rd_req    = '0;
        bus.test_mode = 1'b1;
        repeat (2) tick();
        bus.test_mode = 1'b0;
        tick();

        // Reset inside a read's latency window drops it and restarts arbitration
        bus.rd_addr[2*AW +: AW] = 12'h021;
        bus.rd_req = 4'b0100;
        tick();
        reset_dut();
        repeat (2) tick();
        bus.rd_req = 4'b1111;
        repeat (5) tick();
        bus.rd_req = '0;
        repeat (3) tick();

        // Random client traffic with occasional test-mode windows
        for (int n = 0; n < 400; n++) begin
            rd_pend = rd_pend & ~last_rg;
            wr_pend = wr_pend & ~last_wg;
            for (int i = 0; i < N; i++) begin
                if (!rd_pend[i] && $urandom_range(0, 2) == 0) begin
                    rd_pend[i] = 1'b1;
                    bus.rd_addr[i*AW +: AW] = AW'(12'h100 + $urandom_range(0, 15));
                end
                if (!wr_pend[i] && $urandom_range(0, 3) == 0) begin
                    wr_pend[i] = 1'b1;
                    bus.wr_addr[i*AW +: AW] = AW'(12'h100 + $urandom_range(0, 15));
                    bus.wr_data[i*DW +: DW] = $urandom;
                end
            end
            bus.rd_req = rd_pend;
            bus.wr_req = wr_pend;
            if ($urandom_range(0, 15) == 0) bus.test_mode = ~bus.test_mode;
            bus.test_wr_en   = ($urandom_range(0, 1) == 1);
            bus.test_wr_addr = AW'(12'h100 + $urandom_range(0, 15));
            bus.test_rd_addr = AW'(12'h100 + $urandom_range(0, 15));
            bus.test_wr_data = $urandom;
            tick();
        end
        bus.rd_req    = '0;
        bus.wr_req    = '0;
        bus.test_mode = 1'b0;
        repeat (4) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
